// File: rtl/pipelined_ripple_adder.sv
// Pipelined ripple-carry adder/subtractor: WIDTH-bit operands are added CHUNK bits per
// stage, with the carry, the pending operand slices and the finished sum slices registered between stages.
module pipelined_ripple_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / CHUNK;

  // Ripple chain of full-adder cells. Returns {carry out, carry into top bit, sum}.
  function automatic logic [CHUNK+1:0] ripple(input logic [CHUNK-1:0] x,
                                               input logic [CHUNK-1:0] y,
                                               input logic             c);
    logic [CHUNK-1:0] s;
    logic             cc;
    logic             c_msb;
    s     = '0;
    cc    = c;
    c_msb = c;
    for (int i = 0; i < CHUNK; i++) begin
      c_msb = cc;
      s[i]  = x[i] ^ y[i] ^ cc;
      cc    = (x[i] & y[i]) | ((x[i] ^ y[i]) & cc);
    end
    return {cc, c_msb, s};
  endfunction

  // Rank 0 holds the registered input beat; rank k+1 holds the beat after slice k is added.
  logic [STAGES:0]  vld;
  logic [STAGES:0]  carry;
  logic [WIDTH-1:0] op_a [STAGES];
  logic [WIDTH-1:0] op_b [STAGES];
  logic [WIDTH-1:0] psum [STAGES+1];
  logic             ovf_q;

  logic [CHUNK+1:0] slice_res [STAGES];
  logic [WIDTH-1:0] psum_nxt  [STAGES];
  logic             en;

  assign en        = !vld[STAGES] || out_ready;
  assign in_ready  = en;
  assign out_valid = vld[STAGES];
  assign sum       = psum[STAGES];
  assign cout      = carry[STAGES];
  assign ovf       = ovf_q;

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      slice_res[k] = ripple(op_a[k][k*CHUNK +: CHUNK], op_b[k][k*CHUNK +: CHUNK], carry[k]);
      psum_nxt[k]  = psum[k];
      psum_nxt[k][k*CHUNK +: CHUNK] = slice_res[k][CHUNK-1:0];
    end
  end

  // The whole pipeline advances or holds as one; bubbles travel like beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld   <= '0;
      carry <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        op_a[k] <= '0;
        op_b[k] <= '0;
      end
      for (int k = 0; k <= STAGES; k++) begin
        psum[k] <= '0;
      end
    end else if (en) begin
      vld      <= {vld[STAGES-1:0], in_valid};
      op_a[0]  <= a;
      op_b[0]  <= sub ? ~b : b;
      carry[0] <= sub ? ~cin : cin;
      psum[0]  <= '0;
      for (int k = 0; k < STAGES; k++) begin
        psum[k+1]  <= psum_nxt[k];
        carry[k+1] <= slice_res[k][CHUNK+1];
      end
      for (int k = 0; k < STAGES - 1; k++) begin
        op_a[k+1] <= op_a[k];
        op_b[k+1] <= op_b[k];
      end
      ovf_q <= slice_res[STAGES-1][CHUNK+1] ^ slice_res[STAGES-1][CHUNK];
    end
  end

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Self-checking bench for pipelined_ripple_adder: directed corner cases plus random streams,
// scored against an integer-arithmetic reference model.
module tb_pipelined_ripple_adder;

  localparam int WIDTH  = 16;
  localparam int CHUNK  = 4;
  localparam int STAGES = WIDTH / CHUNK;

  logic             clk       = 1'b0;
  logic             rst       = 1'b1;
  logic             in_valid  = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a         = '0;
  logic [WIDTH-1:0] b         = '0;
  logic             cin       = 1'b0;
  logic             sub       = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    int               acc_cyc;
    bit               seen;
  } exp_t;

  exp_t exp_q[$];
  int   compared     = 0;
  int   mismatched   = 0;
  int   cyc          = 0;
  bit   lat_check    = 1'b1;
  bit   stalled_prev = 1'b0;

  pipelined_ripple_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference: plain unsigned and signed integer arithmetic on the operands.
  function automatic exp_t model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                 input logic cv, input logic sv, input int acc);
    exp_t   e;
    longint ures;
    longint sres;
    longint ua = longint'(av);
    longint ub = longint'(bv);
    longint sa = longint'($signed(av));
    longint sb = longint'($signed(bv));
    longint cc = longint'(cv);
    if (sv) begin
      ures   = ua - ub - cc;
      sres   = sa - sb - cc;
      e.cout = (ures >= 0);
    end else begin
      ures   = ua + ub + cc;
      sres   = sa + sb + cc;
      e.cout = (ures >= (longint'(1) << WIDTH));
    end
    e.sum     = ures[WIDTH-1:0];
    e.ovf     = (sres > ((longint'(1) << (WIDTH-1)) - 1)) || (sres < -(longint'(1) << (WIDTH-1)));
    e.acc_cyc = acc;
    e.seen    = 1'b0;
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                               input logic cv, input logic sv);
    in_valid = v;
    a        = av;
    b        = bv;
    cin      = cv;
    sub      = sv;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    checkOutput("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_directed(input string tag, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                              input logic cv, input logic sv,
                              input logic [WIDTH-1:0] xs, input logic xc, input logic xo);
    applyStimulus(1'b1, av, bv, cv, sv);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (STAGES - 1) tick();
    checkOutput({tag, "_early_valid"}, 32'(out_valid), 32'd0);
    tick();
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, "_sum"},   32'(sum),       32'(xs));
    checkOutput({tag, "_cout"},  32'(cout),      32'(xc));
    checkOutput({tag, "_ovf"},   32'(ovf),       32'(xo));
    drain(10);
  endtask

  // Scoreboard: retire a delivered result, then record an accepted beat, all at the quiet falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("spurious_out_valid", 32'(out_valid), 32'd0);
        end else begin
          checkOutput("stream_sum",  32'(sum),  32'(exp_q[0].sum));
          checkOutput("stream_cout", 32'(cout), 32'(exp_q[0].cout));
          checkOutput("stream_ovf",  32'(ovf),  32'(exp_q[0].ovf));
          if (lat_check && !exp_q[0].seen)
            checkOutput("latency", 32'(cyc - exp_q[0].acc_cyc), 32'(STAGES));
          exp_q[0].seen = 1'b1;
          if (out_ready) void'(exp_q.pop_front());
        end
      end else if (stalled_prev) begin
        checkOutput("hold_out_valid", 32'(out_valid), 32'd1);
      end
      stalled_prev = out_valid && !out_ready;
      if (in_valid && in_ready)
        exp_q.push_back(model(a, b, cin, sub, cyc + 1));
    end else begin
      stalled_prev = 1'b0;
    end
  end

  initial begin
    logic [WIDTH-1:0] held_sum;
    $display("[TB] start");
    tick();
    tick();
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_sum",       32'(sum),       32'd0);
    checkOutput("reset_in_ready",  32'(in_ready),  32'd1);
    rst = 1'b0;
    tick();

    run_directed("carry_ripple", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_directed("ovf_add",      16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_directed("ovf_sub",      16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_directed("sub_borrow",   16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0);

    // Back-to-back random stream with the sink always ready.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom));
      tick();
    end
    drain(20);

    // Sink stalls for 3 cycles while the source keeps offering beats.
    lat_check = 1'b0;
    held_sum  = '0;
    for (int i = 0; i < 14; i++) begin
      out_ready = !(i >= 6 && i <= 8);
      if (!(i >= 7 && i <= 9))
        applyStimulus(1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom));
      #1;
      if (i == 6) held_sum = sum;
      if (i >= 6 && i <= 8) begin
        checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
        checkOutput("stall_sum_hold", 32'(sum), 32'(held_sum));
      end
      tick();
    end
    drain(20);
    lat_check = 1'b1;

    // Reset with three beats in flight; none of them may emerge afterwards.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, WIDTH'($urandom) | 16'h0101, WIDTH'($urandom), 1'b1, 1'b0);
      tick();
    end
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    rst = 1'b1;
    exp_q.delete();
    tick();
    checkOutput("midreset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midreset_sum",       32'(sum),       32'd0);
    checkOutput("midreset_cout",      32'(cout),      32'd0);
    checkOutput("midreset_ovf",       32'(ovf),       32'd0);
    tick();
    rst = 1'b0;
    repeat (2 * STAGES + 2) tick();
    checkOutput("post_reset_idle", 32'(out_valid), 32'd0);

    run_directed("after_reset", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pipelined_ripple_adder.md
Name: pipelined_ripple_adder

Overview:
Parametrised, pipelined ripple-carry adder/subtractor, the wide-word successor of the team's 4-bit gate-level ripple adder. WIDTH-bit operands are split into CHUNK-bit slices. Each slice is a ripple chain of full-adder cells, and each slice boundary is registered, so carries propagate one slice per clock. Supports add with carry-in, subtract with borrow-in, signed-overflow flag, and valid/ready flow control for use in datapaths with back-pressure.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK.
CHUNK, 4, bits per pipeline slice; STAGES = WIDTH/CHUNK; STAGES >= 1.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  synchronous reset, active-high.
in_valid  input  1  operand beat valid.
in_ready  output  1  block can accept a beat this cycle.
a  input  WIDTH  operand A, unsigned or two's complement.
b  input  WIDTH  operand B.
cin  input  1  carry-in (add) or borrow-in (sub).
sub  input  1  0 = A+B+cin; 1 = A-B-cin.
out_valid  output  1  result beat valid.
out_ready  input  1  downstream accepts result.
sum  output  WIDTH  result, modulo 2^WIDTH.
cout  output  1  add: carry-out; sub: 1 = no borrow.
ovf  output  1  two's-complement overflow.

Behaviour:
- Reset (rst=1 at rising clk): all stage valid bits cleared; out_valid=0, sum=0, cout=0, ovf=0. Internal operand and partial-sum registers are cleared to 0. Reset wins over any simultaneous handshake; a beat in flight is discarded.
- Operation: effective B = sub ? ~b : b. Effective carry-in = sub ? ~cin : cin. Result = a + Beff + cineff, computed by ripple full-adder chains (s = x^y^c, co = x&y | (x^y)&c).
- Pipeline: stage k (0..STAGES-1) adds slice k, using the registered carry from stage k-1 (stage 0 uses cineff). Not-yet-added upper slices of a and Beff travel with the beat. Already-computed lower sum slices also travel with the beat.
- Latency: exactly STAGES cycles from an accepted input (in_valid & in_ready at edge N) to out_valid=1 after edge N+STAGES-1+1, i.e. the result is visible in cycle N+STAGES, with no stall.
- Flow control: global enable en = !out_valid | out_ready, and in_ready = en, combinational.
  - When en=1, every stage register shifts forward one stage. Stage 0 loads the input beat with valid = in_valid.
  - When en=0, all stages hold.
  - Bubbles are not collapsed.
- Throughput: one beat per clock while out_ready=1.
- Output hold: while out_valid=1 and out_ready=0, sum/cout/ovf/out_valid are stable.
- cout: carry out of bit WIDTH-1.
- ovf: carry into bit WIDTH-1 XOR carry out of bit WIDTH-1. Computed in the final stage.
- Invalid beats: the datapath may still update, but out_valid must be 0 for them.
- Simultaneous accept and deliver in the same cycle is legal and required.

Test Plan:
- Reset: assert rst for 2 cycles mid-stream with 3 beats in flight -> out_valid=0, sum=0, cout=0, ovf=0 next cycle; none of those 3 beats ever emerges.
- Carry ripple across all slices (WIDTH=16, CHUNK=4): a=16'hFFFF, b=16'h0000, cin=1, sub=0 -> after exactly 4 cycles sum=16'h0000, cout=1, ovf=0.
- Signed overflow: a=16'h7FFF, b=16'h0001, cin=0, sub=0 -> sum=16'h8000, cout=0, ovf=1. Also a=16'h8000, b=16'h0001, sub=1 -> sum=16'h7FFF, cout=1, ovf=1.
- Subtract with borrow: a=16'h0005, b=16'h0007, cin=1, sub=1 -> sum=16'hFFFD, cout=0 (borrow), ovf=0.
- Streaming throughput: 20 back-to-back random beats with out_ready=1 -> 20 results in order, one per cycle, first at latency 4. Each result matches a reference model.
- Back-pressure: stream beats, drop out_ready for 3 cycles -> in_ready=0 during the stall, outputs held constant, no beat lost or duplicated, order preserved after release.
